// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl - handshaked load/store controller between the decode/ALU stage
// and the data memory unit.
//
// Takes one request at a time from the datapath, forms the effective address,
// checks size legality and alignment, and then does one of two things:
//   - raises a one-cycle fault, or
//   - issues an aligned, strobed memory access and holds it until mem_ack.
// Load results are lane-selected, sign/zero extended and returned as a
// one-cycle writeback pulse.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   req_valid / req_ready     request handshake (ready only while idle)
//   is_store, Funct3          access direction and RISC-V size/sign code
//   base_addr, Imm_reg        RS1 data and signed 12-bit offset
//   store_data, RD            RS2 data and load destination register
//   mem_req, mem_we           memory request (held until ack), write enable
//   mem_addr                  word/doubleword-aligned address
//   mem_wdata, mem_wstrb      lane-shifted store data and byte strobes
//   mem_ack, mem_rdata        memory completion and full aligned read word
//   wb_valid, wb_rd, wb_data  one-cycle writeback of the extended load value
//   fault, fault_cause        one-cycle fault pulse; cause held until next fault
//                             (01 misaligned, 10 illegal Funct3, 11 timeout)
//   busy                      controller not idle
// ---------------------------------------------------------------------------
module lsu_ctrl #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               is_store,
   input  logic [2:0]         Funct3,
   input  logic [WIDTH-1:0]   base_addr,
   input  logic [11:0]        Imm_reg,
   input  logic [WIDTH-1:0]   store_data,
   input  logic [4:0]         RD,
   output logic               mem_req,
   output logic               mem_we,
   output logic [WIDTH-1:0]   mem_addr,
   output logic [WIDTH-1:0]   mem_wdata,
   output logic [WIDTH/8-1:0] mem_wstrb,
   input  logic               mem_ack,
   input  logic [WIDTH-1:0]   mem_rdata,
   output logic               wb_valid,
   output logic [4:0]         wb_rd,
   output logic [WIDTH-1:0]   wb_data,
   output logic               fault,
   output logic [1:0]         fault_cause,
   output logic               busy
);

   localparam int unsigned NB   = WIDTH / 8;
   localparam int unsigned LW   = $clog2(NB);
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // Counter value on the last REQ cycle that may still see an ack.
   localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   localparam logic [1:0] CauseMisaligned = 2'b01;
   localparam logic [1:0] CauseIllegal    = 2'b10;
   localparam logic [1:0] CauseTimeout    = 2'b11;

   typedef enum logic [1:0] {StIdle, StReq, StWb, StFault} state_e;

   state_e          state_q;
   logic            is_store_q;
   logic [2:0]      f3_q;
   logic [LW-1:0]   off_q;
   logic [4:0]      rd_q;
   logic [CntW-1:0] cnt_q;

   // ---------------------------------------------------------------------
   // Request decode (only meaningful while idle)
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] ea;
   logic [LW-1:0]    ea_off;
   logic             illegal;
   logic             misaligned;
   logic [NB-1:0]    size_strb;
   logic [WIDTH-1:0] size_mask;
   logic [NB-1:0]    req_strb;
   logic [WIDTH-1:0] req_wdata;

   assign ea     = base_addr + WIDTH'($signed(Imm_reg));
   assign ea_off = ea[LW-1:0];

   always_comb begin
      illegal = 1'b1;
      case (Funct3)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = is_store;
         3'b110:                 illegal = is_store || (WIDTH != 64);
         3'b011:                 illegal = (WIDTH != 64);
         default:                illegal = 1'b1;
      endcase
   end

   // Funct3[1:0] encodes the access size for both signed and unsigned codes.
   always_comb begin
      misaligned = 1'b0;
      size_strb  = {NB{1'b1}};
      size_mask  = {WIDTH{1'b1}};
      case (Funct3[1:0])
         2'b00: begin
            size_strb = NB'(8'h01);
            size_mask = WIDTH'(8'hFF);
         end
         2'b01: begin
            misaligned = ea[0];
            size_strb  = NB'(8'h03);
            size_mask  = WIDTH'(16'hFFFF);
         end
         2'b10: begin
            misaligned = (ea[1:0] != 2'b00);
            size_strb  = NB'(8'h0F);
            size_mask  = WIDTH'(32'hFFFF_FFFF);
         end
         default: begin
            misaligned = (ea[2:0] != 3'b000);
         end
      endcase
   end

   // Aligned accesses never spill past the top lane, so a plain shift suffices.
   assign req_strb  = size_strb << ea_off;
   assign req_wdata = (store_data & size_mask) << {ea_off, 3'b000};

   // ---------------------------------------------------------------------
   // Load lane select and extension
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] rdata_lane;
   logic [WIDTH-1:0] load_ext;

   assign rdata_lane = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      load_ext = rdata_lane;
      case (f3_q)
         3'b000:  load_ext = WIDTH'($signed(rdata_lane[7:0]));
         3'b001:  load_ext = WIDTH'($signed(rdata_lane[15:0]));
         3'b010:  load_ext = WIDTH'($signed(rdata_lane[31:0]));
         3'b100:  load_ext = WIDTH'(rdata_lane[7:0]);
         3'b101:  load_ext = WIDTH'(rdata_lane[15:0]);
         3'b110:  load_ext = WIDTH'(rdata_lane[31:0]);
         default: load_ext = rdata_lane;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         is_store_q  <= 1'b0;
         f3_q        <= 3'b000;
         off_q       <= '0;
         rd_q        <= 5'd0;
         cnt_q       <= '0;
         req_ready   <= 1'b1;
         busy        <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wstrb   <= '0;
         wb_valid    <= 1'b0;
         wb_rd       <= 5'd0;
         wb_data     <= '0;
         fault       <= 1'b0;
         fault_cause <= 2'b00;
      end else begin
         wb_valid <= 1'b0;
         fault    <= 1'b0;
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  is_store_q <= is_store;
                  f3_q       <= Funct3;
                  off_q      <= ea_off;
                  rd_q       <= RD;
                  cnt_q      <= '0;
                  req_ready  <= 1'b0;
                  busy       <= 1'b1;
                  if (illegal || misaligned) begin
                     state_q     <= StFault;
                     fault       <= 1'b1;
                     fault_cause <= illegal ? CauseIllegal : CauseMisaligned;
                  end else begin
                     state_q   <= StReq;
                     mem_req   <= 1'b1;
                     mem_we    <= is_store;
                     mem_addr  <= {ea[WIDTH-1:LW], LW'(0)};
                     mem_wdata <= req_wdata;
                     mem_wstrb <= req_strb;
                  end
               end
            end
            StReq: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wstrb <= '0;
                  if (is_store_q) begin
                     state_q   <= StIdle;
                     req_ready <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     // WB is visited even for RD=0 so load latency stays fixed.
                     state_q  <= StWb;
                     wb_valid <= (rd_q != 5'd0);
                     wb_rd    <= rd_q;
                     wb_data  <= load_ext;
                  end
               end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                  state_q     <= StFault;
                  mem_req     <= 1'b0;
                  mem_we      <= 1'b0;
                  mem_wstrb   <= '0;
                  fault       <= 1'b1;
                  fault_cause <= CauseTimeout;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q   <= StIdle;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl - directed self-checking bench for lsu_ctrl.
// Two instances share the stimulus bus: a 32-bit one with TIMEOUT=4 and a
// 64-bit one with the default timeout; sel64 steers requests and acks.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

   logic        clk;
   logic        rst;
   logic        sel64;
   logic        req_valid;
   logic        is_store;
   logic        mem_ack;
   logic [2:0]  funct3;
   logic [11:0] imm;
   logic [4:0]  rd;
   logic [63:0] base_addr;
   logic [63:0] store_data;
   logic [63:0] mem_rdata;

   logic        a_req_ready, a_mem_req, a_mem_we, a_wb_valid, a_fault, a_busy;
   logic [31:0] a_mem_addr, a_mem_wdata, a_wb_data;
   logic [3:0]  a_mem_wstrb;
   logic [4:0]  a_wb_rd;
   logic [1:0]  a_fault_cause;

   logic        b_req_ready, b_mem_req, b_mem_we, b_wb_valid, b_fault, b_busy;
   logic [63:0] b_mem_addr, b_mem_wdata, b_wb_data;
   logic [7:0]  b_mem_wstrb;
   logic [4:0]  b_wb_rd;
   logic [1:0]  b_fault_cause;

   lsu_ctrl #(.WIDTH(32), .TIMEOUT(4)) u_dut32 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && !sel64), .req_ready(a_req_ready),
      .is_store(is_store), .Funct3(funct3),
      .base_addr(base_addr[31:0]), .Imm_reg(imm),
      .store_data(store_data[31:0]), .RD(rd),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
      .mem_ack(mem_ack && !sel64), .mem_rdata(mem_rdata[31:0]),
      .wb_valid(a_wb_valid), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
      .fault(a_fault), .fault_cause(a_fault_cause), .busy(a_busy)
   );

   lsu_ctrl #(.WIDTH(64), .TIMEOUT(16)) u_dut64 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && sel64), .req_ready(b_req_ready),
      .is_store(is_store), .Funct3(funct3),
      .base_addr(base_addr), .Imm_reg(imm),
      .store_data(store_data), .RD(rd),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
      .mem_ack(mem_ack && sel64), .mem_rdata(mem_rdata),
      .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
      .fault(b_fault), .fault_cause(b_fault_cause), .busy(b_busy)
   );

   // Observation mux onto the selected instance.
   logic        o_req, o_we, o_wbv, o_fault, o_rdy, o_busy;
   logic [63:0] o_addr, o_wdata, o_wbd;
   logic [7:0]  o_wstrb;
   logic [4:0]  o_wbrd;
   logic [1:0]  o_cause;

   assign o_req   = sel64 ? b_mem_req     : a_mem_req;
   assign o_we    = sel64 ? b_mem_we      : a_mem_we;
   assign o_addr  = sel64 ? b_mem_addr    : {32'h0, a_mem_addr};
   assign o_wdata = sel64 ? b_mem_wdata   : {32'h0, a_mem_wdata};
   assign o_wstrb = sel64 ? b_mem_wstrb   : {4'h0, a_mem_wstrb};
   assign o_wbv   = sel64 ? b_wb_valid    : a_wb_valid;
   assign o_wbd   = sel64 ? b_wb_data     : {32'h0, a_wb_data};
   assign o_wbrd  = sel64 ? b_wb_rd       : a_wb_rd;
   assign o_fault = sel64 ? b_fault       : a_fault;
   assign o_cause = sel64 ? b_fault_cause : a_fault_cause;
   assign o_rdy   = sel64 ? b_req_ready   : a_req_ready;
   assign o_busy  = sel64 ? b_busy        : a_busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Snapshots taken by the access tasks.
   logic        s_req, s_we, s_fault, s_wbv, s_rdy, s_held, s_req_after;
   logic [63:0] s_addr, s_wdata, s_wbd;
   logic [7:0]  s_wstrb;
   logic [4:0]  s_wbrd;
   logic [1:0]  s_cause;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one request, accept it, and sample the first cycle after accept.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] base,
                        input logic [11:0] im, input logic [63:0] sd, input logic [4:0] r);
      @(negedge clk);
      req_valid  = 1'b1;
      is_store   = st;
      funct3     = f3;
      base_addr  = base;
      imm        = im;
      store_data = sd;
      rd         = r;
      @(posedge clk);
      #1;
      // Scramble inputs so that only captured values can reach the outputs.
      req_valid  = 1'b0;
      is_store   = ~st;
      funct3     = 3'b111;
      base_addr  = '0;
      imm        = '0;
      store_data = '0;
      rd         = 5'd0;
      @(negedge clk);
      s_req   = o_req;
      s_we    = o_we;
      s_addr  = o_addr;
      s_wstrb = o_wstrb;
      s_wdata = o_wdata;
      s_fault = o_fault;
      s_cause = o_cause;
      s_rdy   = o_rdy;
      s_wbv   = 1'b0;
   endtask

   // Wait 'delay' more request cycles, ack, and sample the cycle after the ack.
   task automatic complete(input int delay, input logic [63:0] rdata);
      s_held = o_req;
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         s_held = s_held & o_req;
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      @(negedge clk);
      s_wbv       = o_wbv;
      s_wbd       = o_wbd;
      s_wbrd      = o_wbrd;
      s_rdy       = o_rdy;
      s_req_after = o_req;
   endtask

   initial begin
      rst = 1'b0; sel64 = 1'b0; req_valid = 1'b0; is_store = 1'b0; mem_ack = 1'b0;
      funct3 = 3'b000; imm = '0; rd = 5'd0; base_addr = '0; store_data = '0; mem_rdata = '0;

      #12;
      check_eq("rst32_ready", {63'h0, a_req_ready}, 64'h1);
      check_eq("rst32_outs", {58'h0, a_mem_req, a_busy, a_wb_valid, a_fault, a_fault_cause},
               64'h0);
      check_eq("rst64_ready", {63'h0, b_req_ready}, 64'h1);
      check_eq("rst64_outs", {58'h0, b_mem_req, b_busy, b_wb_valid, b_fault, b_fault_cause},
               64'h0);
      @(negedge clk);
      rst = 1'b1;

      // LW, ack two cycles after request
      issue(1'b0, 3'b010, 64'h1000, 12'h004, 64'h0, 5'd5);
      check_eq("lw_req", {63'h0, s_req}, 64'h1);
      check_eq("lw_we", {63'h0, s_we}, 64'h0);
      check_eq("lw_addr", s_addr, 64'h1004);
      check_eq("lw_strb", {56'h0, s_wstrb}, 64'h0F);
      check_eq("lw_busy", {62'h0, o_busy, s_rdy}, 64'h2);
      complete(2, 64'hDEAD_BEEF);
      check_eq("lw_held", {63'h0, s_held}, 64'h1);
      check_eq("lw_wbv", {63'h0, s_wbv}, 64'h1);
      check_eq("lw_wbd", s_wbd, 64'hDEAD_BEEF);
      check_eq("lw_wbrd", {59'h0, s_wbrd}, 64'd5);
      check_eq("lw_wb_state", {62'h0, s_rdy, s_req_after}, 64'h0);
      @(negedge clk);
      check_eq("lw_after", {62'h0, o_rdy, o_wbv}, 64'h2);

      // LB / LBU at EA 0x1003 (second one via negative offset)
      issue(1'b0, 3'b000, 64'h1000, 12'h003, 64'h0, 5'd6);
      check_eq("lb_addr", s_addr, 64'h1000);
      check_eq("lb_strb", {56'h0, s_wstrb}, 64'h08);
      complete(0, 64'h8012_3456);
      check_eq("lb_wbd", s_wbd, 64'hFFFF_FF80);
      issue(1'b0, 3'b100, 64'h1004, 12'hFFF, 64'h0, 5'd7);
      check_eq("lbu_addr", s_addr, 64'h1000);
      complete(1, 64'h8012_3456);
      check_eq("lbu_wbd", s_wbd, 64'h0000_0080);

      // SH at EA 0x2002
      issue(1'b1, 3'b001, 64'h2000, 12'h002, 64'h1234_ABCD, 5'd0);
      check_eq("sh_we", {63'h0, s_we}, 64'h1);
      check_eq("sh_strb", {56'h0, s_wstrb}, 64'h0C);
      check_eq("sh_wdata_hi", {48'h0, s_wdata[31:16]}, 64'hABCD);
      complete(1, 64'h0);
      check_eq("sh_no_wb", {63'h0, s_wbv}, 64'h0);
      check_eq("sh_ready", {62'h0, s_rdy, s_req_after}, 64'h2);

      // Faults
      issue(1'b0, 3'b010, 64'h1000, 12'h002, 64'h0, 5'd1);
      check_eq("mis_req", {63'h0, s_req}, 64'h0);
      check_eq("mis_fault", {61'h0, s_fault, s_cause}, 64'h5);
      @(negedge clk);
      check_eq("mis_after", {59'h0, o_req, o_fault, o_rdy, o_cause}, 64'h5);
      issue(1'b1, 3'b101, 64'h1000, 12'h001, 64'h0, 5'd0);
      check_eq("ill_prio", {60'h0, s_req, s_fault, s_cause}, 64'h6);
      issue(1'b0, 3'b110, 64'h1000, 12'h000, 64'h0, 5'd2);
      check_eq("ill_wu32", {60'h0, s_req, s_fault, s_cause}, 64'h6);

      // Timeout: TIMEOUT=4 so mem_req lasts exactly four cycles
      issue(1'b0, 3'b010, 64'h3000, 12'h000, 64'h0, 5'd3);
      s_held = s_req;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         s_held = s_held & o_req;
      end
      check_eq("to_held", {63'h0, s_held}, 64'h1);
      @(negedge clk);
      check_eq("to_fault", {60'h0, o_req, o_fault, o_cause}, 64'h7);
      @(negedge clk);
      check_eq("to_after", {61'h0, o_fault, o_rdy, o_wbv}, 64'h2);

      // Asynchronous reset while in REQ
      issue(1'b0, 3'b010, 64'h1000, 12'h008, 64'h0, 5'd4);
      check_eq("ar_req", {63'h0, s_req}, 64'h1);
      #2;
      rst = 1'b0;
      #1;
      check_eq("ar_async", {59'h0, o_req, o_rdy, o_busy, o_cause}, 64'h8);
      @(negedge clk);
      rst = 1'b1;
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      @(negedge clk);
      check_eq("ack_idle", {61'h0, o_wbv, o_busy, o_rdy}, 64'h1);
      issue(1'b0, 3'b010, 64'h1000, 12'h008, 64'h0, 5'd4);
      check_eq("ar_lw_addr", s_addr, 64'h1008);
      complete(0, 64'h5A5A_A5A5);
      check_eq("ar_lw_wb", {s_wbv, s_wbd[62:0]}, {1'b1, 63'h5A5A_A5A5});

      // 64-bit instance
      sel64 = 1'b1;
      issue(1'b0, 3'b011, 64'h0, 12'h008, 64'h0, 5'd7);
      check_eq("ld_addr", s_addr, 64'h8);
      check_eq("ld_strb", {56'h0, s_wstrb}, 64'hFF);
      complete(1, 64'h0123_4567_89AB_CDEF);
      check_eq("ld_wbd", s_wbd, 64'h0123_4567_89AB_CDEF);
      check_eq("ld_wbv", {63'h0, s_wbv}, 64'h1);
      issue(1'b0, 3'b110, 64'h0, 12'h00C, 64'h0, 5'd8);
      check_eq("lwu_strb", {s_addr[55:0], s_wstrb}, {56'h8, 8'hF0});
      complete(0, 64'h0123_4567_89AB_CDEF);
      check_eq("lwu_wbd", s_wbd, 64'h0000_0000_0123_4567);
      issue(1'b0, 3'b010, 64'h0, 12'h008, 64'h0, 5'd9);
      complete(0, 64'h0123_4567_89AB_CDEF);
      check_eq("lw64_wbd", s_wbd, 64'hFFFF_FFFF_89AB_CDEF);
      issue(1'b0, 3'b011, 64'h0, 12'h008, 64'h0, 5'd0);
      check_eq("rd0_req", {63'h0, s_req}, 64'h1);
      complete(0, 64'h0123_4567_89AB_CDEF);
      check_eq("rd0_wb", {62'h0, s_wbv, s_rdy}, 64'h0);
      @(negedge clk);
      check_eq("rd0_after", {62'h0, o_wbv, o_rdy}, 64'h1);
      issue(1'b1, 3'b011, 64'h10, 12'h000, 64'h1122_3344_5566_7788, 5'd0);
      check_eq("sd_wdata", s_wdata, 64'h1122_3344_5566_7788);
      check_eq("sd_strb", {55'h0, s_we, s_wstrb}, {55'h0, 1'b1, 8'hFF});
      complete(0, 64'h0);
      issue(1'b1, 3'b000, 64'h10, 12'h005, 64'h0000_00AB, 5'd0);
      check_eq("sb64_wdata", s_wdata, 64'h0000_AB00_0000_0000);
      check_eq("sb64_strb", {s_addr[55:0], s_wstrb}, {56'h10, 8'h20});
      complete(0, 64'h0);
      issue(1'b0, 3'b011, 64'h0, 12'h004, 64'h0, 5'd1);
      check_eq("ld_mis", {60'h0, s_req, s_fault, s_cause}, 64'h5);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
